priority_encoder_4to2: RTL

PRIORITY_ENCODER_4TO2 -- requirements
Module: priority_encoder_4to2

---
 rtl/priority_encoder_4to2_pkg.sv | 27 ++
 rtl/priority_encoder_4to2_pe4_select.sv | 55 +++++
 rtl/priority_encoder_4to2.sv | 125 ++++++++++++
 3 files changed

// File: rtl/priority_encoder_4to2_pkg.sv
// Shared definitions for the 4-request priority encoder with ack handshake.
// Holds the FSM state encoding, the request/index width constants and a
// one-hot helper used when clearing the acknowledged request.
// Ports: none (package).
package priority_encoder_4to2_pkg;

    localparam int REQ_W = 4;
    localparam int IDX_W = 2;

    typedef logic [REQ_W-1:0] req_t;
    typedef logic [IDX_W-1:0] idx_t;

    // IDLE: nothing presented (Valid=0); PRESENT: an index is presented (Valid=1).
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // One-hot mask for a request index.
    function automatic req_t idx_onehot(input idx_t idx);
        req_t mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/priority_encoder_4to2_pe4_select.sv
// Combinational request selector: (pending, pointer) -> (index, any).
// Default build: fixed priority, bit 3 highest, bit 0 lowest; no pointer input.
// With ENCODER_ROUND_ROBIN_EN defined: searches upward from pointer, wrapping 3 -> 0.
// Ports:
//   pending  requests eligible for selection
//   pointer  round-robin start position (only with ENCODER_ROUND_ROBIN_EN)
//   index    selected request index (0 when nothing is pending)
//   any      at least one request is pending
module pe4_select
    import priority_encoder_4to2_pkg::*;
(
    input  req_t pending,
`ifdef ENCODER_ROUND_ROBIN_EN
    input  idx_t pointer,
`endif
    output idx_t index,
    output logic any
);

`ifdef ENCODER_ROUND_ROBIN_EN
    idx_t cand;
    logic found;

    always_comb begin
        index = '0;
        found = 1'b0;
        cand  = pointer;
        any   = |pending;
        // Walk the four positions starting at the pointer; the 2-bit add
        // provides the 3 -> 0 wrap for free.
        for (int k = 0; k < REQ_W; k++) begin
            cand = pointer + k[IDX_W-1:0];
            if (!found && pending[cand]) begin
                index = cand;
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        index = '0;
        any   = |pending;
        if (pending[3]) begin
            index = 2'd3;
        end else if (pending[2]) begin
            index = 2'd2;
        end else if (pending[1]) begin
            index = 2'd1;
        end else begin
            index = 2'd0;
        end
    end
`endif

endmodule

// File: rtl/priority_encoder_4to2.sv
// Sticky 4-line request collector that presents one index at a time with a
// Valid/Ack handshake. Requests land in Pending one edge after sampling and are
// presented one edge later; each Ack retires the presented bit and loads the
// next index on the same edge (no bubble). Presented index holds while Ack=0.
// Arbitration: fixed priority by default; round robin when the macro
// ENCODER_ROUND_ROBIN_EN is defined (adds a 2-bit rotation pointer).
// Ports:
//   Clock           rising-edge clock
//   Reset           synchronous active-high reset
//   Enable          1: capture Encoder_Input into Pending; 0: capture blocked only
//   Encoder_Input   request lines, level-sampled each edge
//   Ack             consumer accepts Encoder_Output (ignored while Valid=0)
//   Encoder_Output  presented index, registered
//   Valid           Encoder_Output holds a pending request, registered
//   Pending         sticky pending-request register
module priority_encoder_4to2
    import priority_encoder_4to2_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic [REQ_W-1:0] Encoder_Input,
    input  logic             Ack,
    output logic [IDX_W-1:0] Encoder_Output,
    output logic             Valid,
    output logic [REQ_W-1:0] Pending
);

    state_t state_q, state_d;
    idx_t   idx_q, idx_d;
    req_t   pend_q, pend_d;

    logic   ack_fire;
    req_t   clr_mask;
    req_t   sel_req;
    idx_t   sel_idx;
    logic   sel_any;

    assign ack_fire = (state_q == ST_PRESENT) && Ack;
    assign clr_mask = ack_fire ? idx_onehot(idx_q) : '0;

    // Clear first, then OR in new requests: a request arriving on the bit
    // being acknowledged keeps that bit pending.
    assign pend_d = (pend_q & ~clr_mask) | (Enable ? Encoder_Input : '0);

    // While presenting, the selector looks at what would remain after the
    // current index is retired, so an Ack can load the successor at once.
    // Requests captured on the same edge are not yet visible; they follow
    // the normal one-edge path through Pending.
    assign sel_req = (state_q == ST_PRESENT) ? (pend_q & ~idx_onehot(idx_q)) : pend_q;

`ifdef ENCODER_ROUND_ROBIN_EN
    idx_t ptr_q, ptr_d;
    idx_t sel_ptr;

    // On an Ack the search starts just past the retired index.
    assign ptr_d   = ack_fire ? idx_q + 2'd1 : ptr_q;
    assign sel_ptr = (state_q == ST_PRESENT) ? idx_q + 2'd1 : ptr_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    pe4_select u_select (
        .pending (sel_req),
        .pointer (sel_ptr),
        .index   (sel_idx),
        .any     (sel_any)
    );
`else
    pe4_select u_select (
        .pending (sel_req),
        .index   (sel_idx),
        .any     (sel_any)
    );
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_any) begin
                    state_d = ST_PRESENT;
                    idx_d   = sel_idx;
                end
            end
            ST_PRESENT: begin
                // Without Ack the presented index is frozen, even if a
                // higher-priority request shows up in Pending.
                if (Ack) begin
                    if (sel_any) begin
                        idx_d = sel_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
        end
    end

    assign Encoder_Output = idx_q;
    assign Valid          = (state_q == ST_PRESENT);
    assign Pending        = pend_q;

endmodule
